// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU arbiter: RV32I load/store funct3 codes,
// arbiter FSM states and the request legality/alignment check.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Returns 1 when the request must not reach memory: illegal funct3 for
    // its direction, or a halfword/word address that is not naturally aligned.
    function automatic logic access_err(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        logic legal;
        logic aligned;
        if (we) begin
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        case (funct3[1:0])
            2'b01:   aligned = ~addr_lo[0];
            2'b10:   aligned = (addr_lo == 2'b00);
            default: aligned = 1'b1;
        endcase
        return ~(legal & aligned);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the pointer with
// wrap and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_any
);

    int               pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        pos       = 0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos  = (int'(i_ptr) + k) % NREQ;
            cand = IDX_W'(pos);
            if (!o_any && i_req[cand]) begin
                o_gnt[cand] = 1'b1;
                o_gnt_idx   = cand;
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Round-robin arbiter sharing one data-memory LSU between NREQ requesters.
// Define LSU_ARB_PERF_EN to add grant/stall/error performance counters.
module lsu_arbiter
    import lsu_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NREQ-1:0]        i_req_valid,
    output logic [NREQ-1:0]        o_req_ready,
    input  logic [NREQ-1:0]        i_req_we,
    input  logic [3*NREQ-1:0]      i_req_funct3,
    input  logic [ADDR_W*NREQ-1:0] i_req_addr,
    input  logic [DATA_W*NREQ-1:0] i_req_wdata,
    output logic [NREQ-1:0]        o_rsp_valid,
    input  logic [NREQ-1:0]        i_rsp_ready,
    output logic [DATA_W-1:0]      o_rsp_data,
    output logic                   o_rsp_err,
    output logic [ADDR_W-1:0]      o_lsu_addr,
    output logic [2:0]             o_lsu_funct3,
    output logic [DATA_W-1:0]      o_lsu_st_data,
    output logic                   o_lsu_wren,
    input  logic [DATA_W-1:0]      i_lsu_ld_data
`ifdef LSU_ARB_PERF_EN
    ,
    output logic [32*NREQ-1:0]     o_perf_grants,
    output logic [31:0]            o_perf_stall,
    output logic [15:0]            o_perf_err
`endif
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]   gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic              sel_we;
    logic [2:0]        sel_funct3;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req     (i_req_valid),
        .i_ptr     (ptr_q),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx),
        .o_any     (gnt_any)
    );

    // One-hot grant makes an AND-OR mux sufficient for payload selection.
    always_comb begin
        sel_we     = 1'b0;
        sel_funct3 = '0;
        sel_addr   = '0;
        sel_wdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_we     = sel_we | (gnt[i] & i_req_we[i]);
            sel_funct3 = sel_funct3 | ({3{gnt[i]}} & i_req_funct3[i*3 +: 3]);
            sel_addr   = sel_addr | ({ADDR_W{gnt[i]}} & i_req_addr[i*ADDR_W +: ADDR_W]);
            sel_wdata  = sel_wdata | ({DATA_W{gnt[i]}} & i_req_wdata[i*DATA_W +: DATA_W]);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (i_rsp_ready[win_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; ready is also masked by reset so nothing is offered while held.
    always_comb begin
        o_req_ready = ((state_q == IDLE) && i_reset) ? gnt : '0;
        o_lsu_wren  = (state_q == ACCESS) & we_q & ~err_q;
        o_rsp_err   = (state_q == RESP) & err_q;
        o_rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_rsp_valid[i] = (state_q == RESP) && (win_q == IDX_W'(i));
        end
    end

    assign o_lsu_addr    = addr_q;
    assign o_lsu_funct3  = funct3_q;
    assign o_lsu_st_data = wdata_q;
    assign o_rsp_data    = rsp_data_q;

    always_comb begin
        ptr_d      = ptr_q;
        win_d      = win_q;
        we_d       = we_q;
        err_d      = err_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rsp_data_d = rsp_data_q;
        if (state_q == IDLE && gnt_any) begin
            win_d    = gnt_idx;
            we_d     = sel_we;
            funct3_d = sel_funct3;
            addr_d   = sel_addr;
            wdata_d  = sel_wdata;
            err_d    = access_err(sel_we, sel_funct3, sel_addr[1:0]);
        end
        if (state_q == ACCESS) begin
            rsp_data_d = (!we_q && !err_q) ? i_lsu_ld_data : '0;
            ptr_d      = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ptr_q      <= '0;
            win_q      <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            we_q       <= we_d;
            err_q      <= err_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef LSU_ARB_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [15:0] errcnt_q, errcnt_d;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant_cnt
        logic [31:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (o_req_ready[gi] && !(&cnt_q)) cnt_d = cnt_q + 32'd1;
        end
        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) cnt_q <= '0;
            else          cnt_q <= cnt_d;
        end
        assign o_perf_grants[gi*32 +: 32] = cnt_q;
    end

    // Errors are counted once per transaction, in its ACCESS cycle.
    always_comb begin
        stall_d  = stall_q;
        errcnt_d = errcnt_q;
        if (|(i_req_valid & ~o_req_ready) && !(&stall_q)) stall_d = stall_q + 32'd1;
        if (state_q == ACCESS && err_q && !(&errcnt_q)) errcnt_d = errcnt_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_q  <= '0;
            errcnt_q <= '0;
        end else begin
            stall_q  <= stall_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign o_perf_stall = stall_q;
    assign o_perf_err   = errcnt_q;
`endif

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed self-checking bench for lsu_arbiter (NREQ=2): load, store,
// errors, contention, response backpressure and reset during ACCESS.
module tb_lsu_arbiter;

    localparam int NREQ = 2;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ-1:0]   o_req_ready;
    logic [NREQ-1:0]   i_req_we;
    logic [3*NREQ-1:0] i_req_funct3;
    logic [32*NREQ-1:0] i_req_addr;
    logic [32*NREQ-1:0] i_req_wdata;
    logic [NREQ-1:0]   o_rsp_valid;
    logic [NREQ-1:0]   i_rsp_ready;
    logic [31:0]       o_rsp_data;
    logic              o_rsp_err;
    logic [31:0]       o_lsu_addr;
    logic [2:0]        o_lsu_funct3;
    logic [31:0]       o_lsu_st_data;
    logic              o_lsu_wren;
    logic [31:0]       i_lsu_ld_data;
`ifdef LSU_ARB_PERF_EN
    logic [32*NREQ-1:0] o_perf_grants;
    logic [31:0]        o_perf_stall;
    logic [15:0]        o_perf_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    lsu_arbiter #(.NREQ(NREQ), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_we      (i_req_we),
        .i_req_funct3  (i_req_funct3),
        .i_req_addr    (i_req_addr),
        .i_req_wdata   (i_req_wdata),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_err     (o_rsp_err),
        .o_lsu_addr    (o_lsu_addr),
        .o_lsu_funct3  (o_lsu_funct3),
        .o_lsu_st_data (o_lsu_st_data),
        .o_lsu_wren    (o_lsu_wren),
        .i_lsu_ld_data (i_lsu_ld_data)
`ifdef LSU_ARB_PERF_EN
        ,
        .o_perf_grants (o_perf_grants),
        .o_perf_stall  (o_perf_stall),
        .o_perf_err    (o_perf_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 4ns later.
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
        i_req_we[p]             = we;
        i_req_funct3[p*3 +: 3]  = f3;
        i_req_addr[p*32 +: 32]  = addr;
        i_req_wdata[p*32 +: 32] = wdata;
    endtask

    logic [NREQ-1:0] exp_gnt;

    initial begin
        i_reset       = 1'b0;
        i_req_valid   = 2'b01;
        i_req_we      = '0;
        i_req_funct3  = '0;
        i_req_addr    = '0;
        i_req_wdata   = '0;
        i_rsp_ready   = 2'b11;
        i_lsu_ld_data = '0;

        // Reset state (a valid request must not be acknowledged while held).
        next_cycle();
        #4;
        check("rst_req_ready", o_req_ready, 2'b00);
        check("rst_rsp_valid", o_rsp_valid, 2'b00);
        check("rst_wren", o_lsu_wren, 1'b0);
        check("rst_lsu_addr", o_lsu_addr, 32'h0);
        check("rst_rsp_data", o_rsp_data, 32'h0);
        check("rst_rsp_err", o_rsp_err, 1'b0);
        next_cycle();
        i_req_valid = '0;
        next_cycle();
        i_reset = 1'b1;
        next_cycle();

        // Single load: port0 LW 0x10.
        set_port(0, 1'b0, 3'b010, 32'h10, 32'h0);
        i_lsu_ld_data = 32'hDEADBEEF;
        i_req_valid   = 2'b01;
        #4;
        check("ld_ready", o_req_ready, 2'b01);
        next_cycle();
        i_req_valid = '0;
        #4;
        check("ld_access_wren", o_lsu_wren, 1'b0);
        check("ld_access_addr", o_lsu_addr, 32'h10);
        check("ld_access_f3", o_lsu_funct3, 3'b010);
        check("ld_access_ready", o_req_ready, 2'b00);
        next_cycle();
        #4;
        check("ld_rsp_valid", o_rsp_valid, 2'b01);
        check("ld_rsp_data", o_rsp_data, 32'hDEADBEEF);
        check("ld_rsp_err", o_rsp_err, 1'b0);
        next_cycle();

        // Single store: port1 SW 0x20.
        set_port(1, 1'b1, 3'b010, 32'h20, 32'h12345678);
        i_req_valid = 2'b10;
        #4;
        check("st_ready", o_req_ready, 2'b10);
        check("st_idle_wren", o_lsu_wren, 1'b0);
        next_cycle();
        i_req_valid = '0;
        #4;
        check("st_access_wren", o_lsu_wren, 1'b1);
        check("st_access_addr", o_lsu_addr, 32'h20);
        check("st_access_data", o_lsu_st_data, 32'h12345678);
        next_cycle();
        #4;
        check("st_rsp_wren", o_lsu_wren, 1'b0);
        check("st_rsp_valid", o_rsp_valid, 2'b10);
        check("st_rsp_data", o_rsp_data, 32'h0);
        check("st_rsp_err", o_rsp_err, 1'b0);
        next_cycle();

        // Misaligned SH at 0x3 on port0.
        set_port(0, 1'b1, 3'b001, 32'h3, 32'hFFFF);
        i_req_valid = 2'b01;
        #4;
        check("mis_ready", o_req_ready, 2'b01);
        next_cycle();
        i_req_valid = '0;
        #4;
        check("mis_access_wren", o_lsu_wren, 1'b0);
        next_cycle();
        #4;
        check("mis_rsp_err", o_rsp_err, 1'b1);
        check("mis_rsp_data", o_rsp_data, 32'h0);
        next_cycle();

        // Aligned LW at 0x4 on port0 follows cleanly.
        set_port(0, 1'b0, 3'b010, 32'h4, 32'h0);
        i_lsu_ld_data = 32'hCAFEF00D;
        i_req_valid   = 2'b01;
        next_cycle();
        i_req_valid = '0;
        next_cycle();
        #4;
        check("lw4_rsp_err", o_rsp_err, 1'b0);
        check("lw4_rsp_data", o_rsp_data, 32'hCAFEF00D);
        next_cycle();

        // Illegal load funct3 (3'b011) on port1; pointer then returns to 0.
        set_port(1, 1'b0, 3'b011, 32'h0, 32'h0);
        i_req_valid = 2'b10;
        next_cycle();
        i_req_valid = '0;
        next_cycle();
        #4;
        check("ill_rsp_valid", o_rsp_valid, 2'b10);
        check("ill_rsp_err", o_rsp_err, 1'b1);
        check("ill_rsp_data", o_rsp_data, 32'h0);
        next_cycle();

        // Contention: both continuously valid, grants alternate 0,1,0,1.
        set_port(0, 1'b0, 3'b010, 32'h100, 32'h0);
        set_port(1, 1'b0, 3'b010, 32'h200, 32'h0);
        i_lsu_ld_data = 32'h55;
        i_req_valid   = 2'b11;
        for (int t = 0; t < 4; t++) begin
            exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
            #4;
            check($sformatf("cont_grant%0d", t), o_req_ready, exp_gnt);
            next_cycle();
            #4;
            check($sformatf("cont_addr%0d", t), o_lsu_addr, (t % 2 == 0) ? 32'h100 : 32'h200);
            next_cycle();
            #4;
            check($sformatf("cont_rsp%0d", t), o_rsp_valid, exp_gnt);
            next_cycle();
        end
        i_req_valid = '0;
`ifdef LSU_ARB_PERF_EN
        #4;
        check("perf_stall_nz", (o_perf_stall != 0), 1'b1);
        check("perf_grant0", o_perf_grants[31:0], 32'd5);
`endif
        next_cycle();

        // Backpressure: port0 response held 5 cycles; port1 waits.
        set_port(0, 1'b0, 3'b001, 32'h2, 32'h0);
        set_port(1, 1'b0, 3'b010, 32'h40, 32'h0);
        i_lsu_ld_data = 32'hA5A51234;
        i_rsp_ready   = 2'b10;
        i_req_valid   = 2'b11;
        #4;
        check("bp_grant0", o_req_ready, 2'b01);
        next_cycle();
        i_req_valid = 2'b10;
        next_cycle();
        i_lsu_ld_data = 32'h0BADF00D;
        for (int c = 0; c < 5; c++) begin
            #4;
            check($sformatf("bp_hold_valid%0d", c), o_rsp_valid, 2'b01);
            check($sformatf("bp_hold_data%0d", c), o_rsp_data, 32'hA5A51234);
            check($sformatf("bp_no_grant%0d", c), o_req_ready, 2'b00);
            next_cycle();
        end
        i_rsp_ready = 2'b01;
        #4;
        check("bp_last_valid", o_rsp_valid, 2'b01);
        next_cycle();
        #4;
        check("bp_grant1", o_req_ready, 2'b10);
        next_cycle();
        i_req_valid = '0;
        i_rsp_ready = 2'b11;
        next_cycle();
        #4;
        check("bp_rsp1_valid", o_rsp_valid, 2'b10);
        check("bp_rsp1_data", o_rsp_data, 32'h0BADF00D);
        next_cycle();

        // Reset asserted during a port0 store's ACCESS cycle.
        set_port(0, 1'b1, 3'b010, 32'h80, 32'h11);
        i_req_valid = 2'b01;
        #4;
        check("rs_grant", o_req_ready, 2'b01);
        next_cycle();
        i_req_valid = '0;
        #1;
        check("rs_wren_before", o_lsu_wren, 1'b1);
        i_reset = 1'b0;
        #1;
        check("rs_wren_async", o_lsu_wren, 1'b0);
        check("rs_addr", o_lsu_addr, 32'h0);
        check("rs_st_data", o_lsu_st_data, 32'h0);
        next_cycle();
        #1;
        check("rs_wren_held", o_lsu_wren, 1'b0);
        check("rs_rsp_valid", o_rsp_valid, 2'b00);
        i_reset     = 1'b1;
        i_req_valid = 2'b11;
        #3;
        check("rs_ptr_port0", o_req_ready, 2'b01);
        next_cycle();
        i_req_valid = '0;
        #4;
        check("rs_post_wren", o_lsu_wren, 1'b1);
        check("rs_post_addr", o_lsu_addr, 32'h80);
        next_cycle();
        #4;
        check("rs_post_rsp", o_rsp_valid, 2'b01);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Shares the single data-memory LSU between NREQ requesters, e.g. the core load/store path (port 0) and the program loader/debug port (port 1).
- Accepts requests over valid/ready handshakes and picks a winner round-robin.
- Drives one LSU access per transaction and returns load data or an error flag over a response handshake.
- Sits between the requesters and the LSU's funct3/addr/st_data/wren/ld_data interface.

Parameters:
- NREQ, 2, number of requesters (2..4).
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-low.
- i_req_valid  in  NREQ  per-requester request valid.
- o_req_ready  out  NREQ  one-hot acceptance pulse.
- i_req_we  in  NREQ  1 = store, 0 = load.
- i_req_funct3  in  3*NREQ  RV32I load/store funct3 per requester.
- i_req_addr  in  ADDR_W*NREQ  byte address per requester.
- i_req_wdata  in  DATA_W*NREQ  store data per requester.
- o_rsp_valid  out  NREQ  one-hot response valid.
- i_rsp_ready  in  NREQ  per-requester response ready.
- o_rsp_data  out  DATA_W  load data, zero for stores and errors.
- o_rsp_err  out  1  misaligned or illegal funct3.
- o_lsu_addr  out  ADDR_W  to LSU.
- o_lsu_funct3  out  3  to LSU.
- o_lsu_st_data  out  DATA_W  to LSU.
- o_lsu_wren  out  1  to LSU store enable.
- i_lsu_ld_data  in  DATA_W  from LSU, combinational load result.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer selects port 0 as first priority.
- Reset asserted mid-transaction aborts it immediately. No o_lsu_wren may occur after reset assertion.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any i_req_valid is set, choose the winner starting at the pointer and searching upward with wrap.
  - Pulse o_req_ready[winner] for exactly that cycle.
  - Latch we, funct3, addr, wdata and winner, then go to ACCESS.
  - If no request is valid, stay in IDLE and keep o_lsu_wren at 0.
- Payload rule: a requester holds its payload stable while valid and not yet ready. It may withdraw valid only after ready.
- Error check at latch time:
  - funct3 must be legal: LB, LH, LW, LBU, LHU for loads; SB, SH, SW for stores.
  - Halfword accesses need addr[0]=0.
  - Word accesses need addr[1:0]=0.
  - A failing request sets the latched err bit.
- ACCESS (exactly 1 cycle):
  - o_lsu_addr, o_lsu_funct3 and o_lsu_st_data equal the latched values.
  - o_lsu_wren = we & ~err.
  - Load data is captured from i_lsu_ld_data at the end of the cycle; errors and stores capture 0.
  - The pointer updates to (winner+1) mod NREQ.
  - Next state is RESP.
- Outside ACCESS, o_lsu_wren = 0 and the other LSU outputs hold their last values.
- RESP:
  - o_rsp_valid[winner]=1; o_rsp_data and o_rsp_err are held stable.
  - Leave for IDLE on the cycle i_rsp_ready[winner]=1.
  - Ready on other ports is ignored.
- Throughput and latency: minimum 3 cycles per transaction. No new acceptance occurs while in ACCESS or RESP.
- Fairness: with all ports continuously valid, grants rotate 0,1,..,NREQ-1,0.
- A requester that is valid while another holds the arbiter waits, with no loss of request.
- Simultaneous events: valid on multiple ports in IDLE yields exactly one grant. A requester re-requesting in the cycle after its response waits one full round if others are pending.

Optional Feature:
- LSU_ARB_PERF_EN, when defined, adds:
  - o_perf_grants: 32*NREQ saturating per-port grant counters.
  - o_perf_stall: 32-bit saturating counter of cycles in which some i_req_valid is set without its o_req_ready.
  - o_perf_err: 16-bit error counter.
  - All counters reset to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams (LB/LH/LW/LBU/LHU, SB/SH/SW).
  - arbiter state enum {IDLE, ACCESS, RESP}.
  - the legality/alignment check function.
- One natural sub-module: rr_arbiter. It is a combinational round-robin picker: inputs request vector and pointer, output one-hot grant plus grant index.

Test Plan:
- Single load: port0 LW addr 0x10, i_lsu_ld_data=0xDEADBEEF -> o_req_ready[0] pulses at cycle 0, o_lsu_wren=0 at cycle 1, o_rsp_valid[0] at cycle 2 with data 0xDEADBEEF and err=0.
- Single store: port1 SW addr 0x20 wdata 0x12345678 -> o_lsu_wren=1 for exactly one cycle with addr 0x20 and st_data 0x12345678; response data 0, err 0.
- Contention: both ports valid continuously for 4 transactions -> grant order 0,1,0,1; no port is starved; stall counter (if enabled) nonzero.
- Misaligned: port0 SH addr 0x3 -> o_lsu_wren stays 0 and o_rsp_err=1; a subsequent LW at 0x4 gives err=0.
- Backpressure: i_rsp_ready[0] held low for 5 cycles -> o_rsp_valid[0] and data held stable; port1 is not granted until port0's response is taken.
- Reset mid-ACCESS: assert i_reset low during a store's ACCESS cycle -> o_lsu_wren drops asynchronously, all outputs go to 0, state IDLE, pointer at port 0.
